// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full_adder, one operand bit per clock, LSB first.
// Optional subtract path is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_start_ready;
  logic             r_res_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;

  logic             w_s;
  logic             w_c_out;
  logic [WIDTH-1:0] w_sum_next;

  full_adder u_fa (
    .a     (r_a_sr[0]),
    .b     (r_b_sr[0]),
    .c_in  (r_carry),
    .s     (w_s),
    .c_out (w_c_out)
  );

  assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};

`ifndef SERIAL_ADDER_SUB_EN
  logic w_unused_sub;
  assign w_unused_sub = sub;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_a_sr        <= '0;
      r_b_sr        <= '0;
      r_sum_sr      <= '0;
      r_carry       <= 1'b0;
      r_cnt         <= '0;
      r_start_ready <= 1'b1;
      r_res_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_sum         <= '0;
      r_carry_out   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a_sr        <= op_a;
`ifdef SERIAL_ADDER_SUB_EN
            // Subtraction as A + ~B + 1: invert B and preset the carry.
            r_b_sr        <= sub ? ~op_b : op_b;
            r_carry       <= sub;
`else
            r_b_sr        <= op_b;
            r_carry       <= 1'b0;
`endif
            r_cnt         <= '0;
            r_state       <= RUN;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_sum_sr <= w_sum_next;
          r_carry  <= w_c_out;
          r_cnt    <= r_cnt + 1'b1;
          // Result registers only move on the edge that enters DONE.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state     <= DONE;
            r_res_valid <= 1'b1;
            r_sum       <= w_sum_next;
            r_carry_out <= w_c_out;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state       <= IDLE;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_res_valid   <= 1'b0;
          r_busy        <= 1'b0;
          r_start_ready <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign res_valid   = r_res_valid;
  assign busy        = r_busy;
  assign sum         = r_sum;
  assign carry_out   = r_carry_out;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH = 8): vector table plus
// hand-written back-pressure and mid-run reset sequences.

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;

  int numCompared;
  int numFailed;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .carry_out   (carry_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] expSum;
    logic       expCout;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numCompared++;
    if (act !== exp) begin
      numFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation and return the cycles from accept edge to res_valid (0 on timeout).
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic s,
                               output int latency);
    int waitCnt;
    waitCnt = 0;
    latency = 0;
    while (!start_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    op_a        = a;
    op_b        = b;
    sub         = s;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    op_a        = 8'hC3;
    op_b        = 8'h3C;
    sub         = ~s;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (res_valid) begin
        latency = k;
        break;
      end
    end
  endtask

  task automatic finishHandshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("start_ready_after_hs", 32'(start_ready), 32'd1);
    checkOutput("res_valid_after_hs", 32'(res_valid), 32'd0);
  endtask

  initial begin
    vec_t vecs[11];
    int   lat;
    logic [7:0] heldSum;
    logic       heldCout;
    int   stableBad;

    numCompared = 0;
    numFailed   = 0;

    vecs[0]  = '{8'h10, 8'h01, 1'b1,
`ifdef SERIAL_ADDER_SUB_EN
                 8'h0F, 1'b1};
`else
                 8'h11, 1'b0};
`endif
    vecs[1]  = '{8'h01, 8'h02, 1'b1,
`ifdef SERIAL_ADDER_SUB_EN
                 8'hFF, 1'b0};
`else
                 8'h03, 1'b0};
`endif
    vecs[2]  = '{8'h05, 8'h05, 1'b1,
`ifdef SERIAL_ADDER_SUB_EN
                 8'h00, 1'b1};
`else
                 8'h0A, 1'b0};
`endif
    vecs[3]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    vecs[5]  = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[6]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[9]  = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
    vecs[10] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    rst         = 1'b1;
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    sub         = 1'b0;
    res_ready   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_start_ready", 32'(start_ready), 32'd1);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_carry_out", 32'(carry_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors, each with latency, result and handshake checks.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, lat);
      checkOutput($sformatf("latency[%0d]", i), 32'(lat), 32'd8);
      checkOutput($sformatf("sum[%0d]", i), 32'(sum), 32'(vecs[i].expSum));
      checkOutput($sformatf("carry_out[%0d]", i), 32'(carry_out), 32'(vecs[i].expCout));
      checkOutput($sformatf("busy_done[%0d]", i), 32'(busy), 32'd1);
      finishHandshake();
    end

    // Back-pressure: hold DONE for 5 cycles while pulsing start_valid.
    applyStimulus(8'h5A, 8'h33, 1'b0, lat);
    checkOutput("bp_latency", 32'(lat), 32'd8);
    heldSum   = sum;
    heldCout  = carry_out;
    checkOutput("bp_sum_initial", 32'(heldSum), 32'h8D);
    stableBad = 0;
    for (int c = 0; c < 5; c++) begin
      start_valid = 1'b1;
      op_a        = 8'h01;
      op_b        = 8'h01;
      @(negedge clk);
      start_valid = 1'b0;
      if (sum !== heldSum || carry_out !== heldCout || res_valid !== 1'b1 || start_ready !== 1'b0)
        stableBad++;
    end
    checkOutput("bp_hold_stable", 32'(stableBad), 32'd0);
    finishHandshake();
    checkOutput("bp_no_new_op_busy", 32'(busy), 32'd0);
    checkOutput("bp_sum_kept_in_idle", 32'(sum), 32'h8D);

    // Asynchronous reset in the middle of a RUN phase.
    op_a        = 8'h12;
    op_b        = 8'h34;
    sub         = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid_run_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_start_ready", 32'(start_ready), 32'd1);
    checkOutput("async_rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_sum", 32'(sum), 32'd0);
    checkOutput("async_rst_carry_out", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("no_result_after_rst", 32'(res_valid), 32'd0);
    applyStimulus(8'h12, 8'h34, 1'b0, lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd8);
    checkOutput("post_rst_sum", 32'(sum), 32'h46);
    checkOutput("post_rst_carry_out", 32'(carry_out), 32'd0);
    finishHandshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numFailed);
    $finish;
  end

endmodule
